// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type and default widths for the matmul core.
package matmul_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DIM_W_DEF  = 8;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_e;
endpackage

// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: latched job geometry, i/j/k counters and A/B/D address arithmetic.
module matmul_addr_gen import matmul_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DIM_W     = DIM_W_DEF,
  parameter int NUM_CORES = 1,
  parameter int CORE_ID   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              inc_k_i,
  input  logic              adv_i,
  input  logic [DIM_W-1:0]  di_i,
  input  logic [DIM_W-1:0]  dj_i,
  input  logic [DIM_W-1:0]  dk_i,
  input  logic [ADDR_W-1:0] ba_i,
  input  logic [ADDR_W-1:0] bb_i,
  input  logic [ADDR_W-1:0] bd_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [ADDR_W-1:0] addr_d_o,
  output logic              last_k_o,
  output logic              last_row_o,
  output logic              empty_o
);
  localparam logic [DIM_W:0] NC  = (DIM_W+1)'(NUM_CORES);
  localparam logic [DIM_W:0] CID = (DIM_W+1)'(CORE_ID);
  localparam logic [DIM_W:0] ONE = (DIM_W+1)'(1);
  logic [DIM_W:0] di_q, dj_q, dk_q, i_q, j_q, k_q;
  logic [ADDR_W-1:0] ba_q, bb_q, bd_q;
  logic [2*DIM_W+1:0] ik, kj, ij;
  logic last_j;
  assign ik = i_q * dk_q;
  assign kj = k_q * dj_q;
  assign ij = i_q * dj_q;
  assign addr_a_o = ba_q + ADDR_W'(ik) + ADDR_W'(k_q);
  assign addr_b_o = bb_q + ADDR_W'(kj) + ADDR_W'(j_q);
  assign addr_d_o = bd_q + ADDR_W'(ij) + ADDR_W'(j_q);
  assign last_k_o = k_q + ONE == dk_q;
  assign last_j = j_q + ONE == dj_q;
  // Counters are one bit wider than a dimension so i + NUM_CORES cannot wrap here.
  assign last_row_o = last_j && (i_q + NC >= di_q);
  assign empty_o = di_i == '0 || dj_i == '0 || dk_i == '0 || {1'b0, di_i} <= CID;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {di_q, dj_q, dk_q, i_q, j_q, k_q} <= '0;
      {ba_q, bb_q, bd_q} <= '0;
    end else if (load_i) begin
      di_q <= {1'b0, di_i};
      dj_q <= {1'b0, dj_i};
      dk_q <= {1'b0, dk_i};
      ba_q <= ba_i;
      bb_q <= bb_i;
      bd_q <= bd_i;
      i_q  <= CID;
      j_q  <= '0;
      k_q  <= '0;
    end else if (inc_k_i) begin
      k_q <= k_q + ONE;
    end else if (adv_i) begin
      k_q <= '0;
      j_q <= last_j ? '0 : j_q + ONE;
      i_q <= last_j ? i_q + NC : i_q;
    end
  end
endmodule

// File: rtl/matmul_core.sv
// matmul_core: sequential signed matrix multiply D = A*B over a shared data memory; MATMUL_SAT_EN selects saturating writeback.
module matmul_core import matmul_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DIM_W     = DIM_W_DEF,
  parameter int NUM_CORES = 1,
  parameter int CORE_ID   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [DIM_W-1:0]  dim_j,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);
  state_e state_q;
  logic signed [2*DATA_W-1:0] acc_q, a_x, b_x, prod;
  logic [DATA_W-1:0] a_q, res;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_d;
  logic last_k, last_row, empty;
  matmul_addr_gen #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .NUM_CORES(NUM_CORES), .CORE_ID(CORE_ID)
  ) u_agen (
    .clock(clock), .reset(reset),
    .load_i(state_q == IDLE && start),
    .inc_k_i(state_q == MAC && !last_k),
    .adv_i(state_q == WR),
    .di_i(dim_i), .dj_i(dim_j), .dk_i(dim_k),
    .ba_i(base_a), .bb_i(base_b), .bd_i(base_d),
    .addr_a_o(addr_a), .addr_b_o(addr_b), .addr_d_o(addr_d),
    .last_k_o(last_k), .last_row_o(last_row), .empty_o(empty)
  );
  assign a_x  = {{DATA_W{a_q[DATA_W-1]}}, a_q};
  assign b_x  = {{DATA_W{mem_rdata[DATA_W-1]}}, mem_rdata};
  assign prod = a_x * b_x;
`ifdef MATMUL_SAT_EN
  logic [DATA_W:0] hi;
  assign hi  = acc_q[2*DATA_W-1:DATA_W-1];
  assign res = (&hi || ~|hi) ? acc_q[DATA_W-1:0]
                             : {acc_q[2*DATA_W-1], {(DATA_W-1){~acc_q[2*DATA_W-1]}}};
`else
  assign res = acc_q[DATA_W-1:0];
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= empty ? DONE : RD_A;
          acc_q   <= '0;
        end
        RD_A: state_q <= RD_B;
        RD_B: begin
          a_q     <= mem_rdata;
          state_q <= MAC;
        end
        MAC: begin
          acc_q   <= acc_q + prod;
          state_q <= last_k ? WR : RD_A;
        end
        WR: begin
          acc_q   <= '0;
          state_q <= last_row ? DONE : RD_A;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_addr  = state_q == RD_A ? addr_a : state_q == RD_B ? addr_b : state_q == WR ? addr_d : '0;
  assign mem_we    = state_q == WR;
  assign mem_wdata = mem_we ? res : '0;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_matmul_core.sv
// tb_matmul_core: scoreboard bench for matmul_core (single core and core 1 of 2).
module tb_matmul_core;
  logic clock = 0, reset = 1, st0 = 0, st1 = 0;
  logic [7:0] di = 0, dj = 0, dk = 0, ba = 0, bb = 0, bd = 0;
  logic [7:0] addr0, addr1;
  logic we0, we1, busy0, busy1, done0, done1;
  logic [15:0] wd0, wd1, rd0 = 0, rd1 = 0;
  logic [15:0] mem [256];
  logic [23:0] q0[$], q1[$];
  logic [23:0] e;
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  matmul_core u0 (
    .clock(clock), .reset(reset), .start(st0), .dim_i(di), .dim_j(dj), .dim_k(dk),
    .base_a(ba), .base_b(bb), .base_d(bd), .mem_addr(addr0), .mem_we(we0),
    .mem_wdata(wd0), .mem_rdata(rd0), .busy(busy0), .done(done0)
  );
  matmul_core #(.NUM_CORES(2), .CORE_ID(1)) u1 (
    .clock(clock), .reset(reset), .start(st1), .dim_i(di), .dim_j(dj), .dim_k(dk),
    .base_a(ba), .base_b(bb), .base_d(bd), .mem_addr(addr1), .mem_we(we1),
    .mem_wdata(wd1), .mem_rdata(rd1), .busy(busy1), .done(done1)
  );
  always @(posedge clock) begin
    rd0 <= mem[addr0];
    rd1 <= mem[addr1];
  end
  always @(negedge clock) begin
    if (we0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL u0 write: unexpected addr=%0h data=%0h", addr0, wd0);
      end else begin
        e = q0.pop_front();
        if ({addr0, wd0} !== e) begin
          bad++;
          $display("FAIL u0 write: got addr=%0h data=%0h want addr=%0h data=%0h", addr0, wd0, e[23:16], e[15:0]);
        end
      end
    end
    if (we1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL u1 write: unexpected addr=%0h data=%0h", addr1, wd1);
      end else begin
        e = q1.pop_front();
        if ({addr1, wd1} !== e) begin
          bad++;
          $display("FAIL u1 write: got addr=%0h data=%0h want addr=%0h data=%0h", addr1, wd1, e[23:16], e[15:0]);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic run_job(input bit w, input logic [7:0] i_, j_, k_, a_, b_, d_,
                         input int exp_n, input int extra_at, input int rst_at);
    int n;
    @(negedge clock);
    {di, dj, dk, ba, bb, bd} = {i_, j_, k_, a_, b_, d_};
    if (w) st1 = 1; else st0 = 1;
    @(posedge clock); #1;
    st0 = 0; st1 = 0;
    {di, dj, dk} = {8'($urandom), 8'($urandom), 8'($urandom)};
    {ba, bb, bd} = {8'($urandom), 8'($urandom), 8'($urandom)};
    n = 1;
    while (!(w ? done1 : done0) && n < 300) begin
      if (n == rst_at) begin
        reset = 1;
        #1;
        chk("outputs in reset", {addr0, we0, wd0, busy0, done0}, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 0;
        repeat (12) @(posedge clock);
        #1;
        chk("idle after abort", {busy0, done0, we0}, 0);
        return;
      end
      @(posedge clock); #1;
      n++;
      if (w) st1 = (n == extra_at); else st0 = (n == extra_at);
    end
    st0 = 0; st1 = 0;
    chk("done cycle", n, exp_n);
    chk("busy with done", w ? busy1 : busy0, 1);
    @(posedge clock); #1;
    chk("idle after done", w ? {busy1, done1} : {busy0, done0}, 0);
    repeat (2) @(posedge clock); #1;
    chk("writes drained", w ? q1.size() : q0.size(), 0);
  endtask
  task automatic push_2x2();
    q0.push_back({8'h20, 16'd19});
    q0.push_back({8'h21, 16'd22});
    q0.push_back({8'h22, 16'd43});
    q0.push_back({8'h23, 16'd50});
  endtask
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    {mem[0], mem[1], mem[2], mem[3]} = {16'd1, 16'd2, 16'd3, 16'd4};
    {mem[16], mem[17], mem[18], mem[19]} = {16'd5, 16'd6, 16'd7, 16'd8};
    {mem[64], mem[65], mem[66], mem[67], mem[68], mem[69]} = {16'd9, 16'd9, 16'd3, 16'd4, 16'd9, 16'd9};
    {mem[80], mem[81], mem[82], mem[83]} = {16'h7FFF, 16'h0002, 16'hFFFF, 16'h0003};
    repeat (2) @(posedge clock); #1;
    chk("reset u0", {addr0, we0, wd0, busy0, done0}, 0);
    chk("reset u1", {addr1, we1, wd1, busy1, done1}, 0);
    @(negedge clock) reset = 0;
    push_2x2();
    run_job(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, 29, 0, 0);
    q1.push_back({8'h32, 16'd43});
    q1.push_back({8'h33, 16'd50});
    run_job(1, 3, 2, 2, 8'h40, 8'h10, 8'h30, 15, 0, 0);
`ifdef MATMUL_SAT_EN
    q0.push_back({8'h60, 16'h7FFF});
`else
    q0.push_back({8'h60, 16'hFFFE});
`endif
    run_job(0, 1, 1, 1, 8'h50, 8'h51, 8'h60, 5, 0, 0);
    q0.push_back({8'h61, 16'hFFFD});
    run_job(0, 1, 1, 1, 8'h52, 8'h53, 8'h61, 5, 0, 0);
    run_job(0, 2, 2, 0, 8'h00, 8'h10, 8'h20, 1, 0, 0);
    run_job(1, 1, 1, 1, 8'h00, 8'h10, 8'h20, 1, 0, 0);
    run_job(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, 0, 0, 3);
    chk("no writes after abort", q0.size(), 0);
    push_2x2();
    run_job(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, 29, 0, 0);
    push_2x2();
    run_job(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, 29, 5, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matmul_core.md
MATMUL_CORE -- requirements
Module: matmul_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, element and memory data width.
REQ-002 SHALL have parameter ADDR_W, default 8, data memory address width.
REQ-003 SHALL have parameter DIM_W, default 8, width of each matrix dimension.
REQ-004 SHALL have parameter NUM_CORES, default 1, number of cores sharing one job.
REQ-005 SHALL have parameter CORE_ID, default 0, this core's row offset, 0..NUM_CORES-1.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle job request, sampled in IDLE only.
REQ-010 dim_i, dim_j, dim_k  in  DIM_W each  rows of A, columns of B, inner dimension.
REQ-011 base_a, base_b, base_d  in  ADDR_W each  row-major base addresses of A, B, D.
REQ-012 mem_addr  out  ADDR_W  data memory address.
REQ-013 mem_we  out  1  write strobe, one cycle per result element.
REQ-014 mem_wdata  out  DATA_W  result element.
REQ-015 mem_rdata  in  DATA_W  read data, valid one cycle after mem_addr.
REQ-016 busy  out  1  high from the cycle after start through the DONE state.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 SHALL compute D[i][j] = sum over k of A[i][k]*B[k][j], treating elements as signed, for rows i = CORE_ID, CORE_ID+NUM_CORES, ... < dim_i.
REQ-019 SHALL latch dim_* and base_* on an accepted start; later changes SHALL have no effect on the running job.
REQ-020 Addresses: A = base_a + i*dim_k + k; B = base_b + k*dim_j + j; D = base_d + i*dim_j + j; all modulo 2^ADDR_W.
REQ-021 States: IDLE, RD_A, RD_B, MAC, WR, DONE.
- IDLE: start accepted -> RD_A, with the accumulator cleared and i, j, k set to CORE_ID, 0, 0.
- RD_A: drive A address -> RD_B.
- RD_B: capture A, drive B address -> MAC.
- MAC: capture B, acc += A*B, with acc signed 2*DATA_W. k < dim_k-1 -> k+1 and RD_A; else WR.
- WR: mem_we=1, D address, write acc; advance j, or on wrap j=0 and i+=NUM_CORES; clear acc and k. More rows remain -> RD_A, else DONE.
- DONE: done=1 -> IDLE.
REQ-022 Latency SHALL be exactly R*dim_j*(3*dim_k+1)+1 cycles from the start edge to the cycle with done=1, where R is the number of rows owned by this core.
REQ-023 If any dimension is 0 or CORE_ID >= dim_i, the core SHALL go IDLE -> DONE directly, with no memory accesses and done in the first cycle.
REQ-024 start while busy SHALL be ignored, not queued.
REQ-025 mem_we SHALL be 0 in every state except WR; mem_addr SHALL be 0 in IDLE and DONE.
REQ-026 The i, j, k counters SHALL be DIM_W+1 bits wide, so that i+NUM_CORES never wraps before the row comparison.

Reset
REQ-027 Reset SHALL force IDLE and set mem_addr, mem_we, mem_wdata, busy, done, the accumulator and all counters to 0, asynchronously.
REQ-028 Reset mid-job SHALL abort the job with no further writes; the next job requires a new start.

Configuration
REQ-029 Macro MATMUL_SAT_EN defined: in WR, mem_wdata SHALL be acc saturated to the signed DATA_W range.
REQ-030 MATMUL_SAT_EN undefined: mem_wdata SHALL be acc[DATA_W-1:0] (wrap).

Structure
REQ-031 Package matmul_pkg SHALL hold the state enum type and the default DATA_W/ADDR_W/DIM_W constants.
REQ-032 The counters and address arithmetic SHALL be in sub-module matmul_addr_gen; the FSM, accumulator and saturation SHALL stay in matmul_core.

Verification
REQ-033 2x2x2 job: A=[1,2;3,4] at 0x00, B=[5,6;7,8] at 0x10, base_d=0x20 -> writes 19,22,43,50 to 0x20..0x23; done at cycle 29.
REQ-034 NUM_CORES=2, CORE_ID=1, 3x2x2 job -> only row 1 is written (addresses base_d+2, base_d+3); done at cycle 15.
REQ-035 A=0x7FFF, B=0x0002, dimensions 1x1x1 -> writes 0xFFFE without MATMUL_SAT_EN and 0x7FFF with it; done at cycle 5.
REQ-036 dim_k=0, then separately CORE_ID=1 with dim_i=1 -> no mem_we and done in cycle 1.
REQ-037 Reset asserted during MAC of the 2x2x2 job -> all outputs are 0 immediately and no writes occur; a new start then reproduces REQ-033.
REQ-038 A second start pulse at cycle 5 of a running job -> ignored; results and done cycle are identical to REQ-033.
